// File: rtl/huffman_stream_encoder_pkg.sv
// Shared types and width helpers for the streaming Huffman encoder.
//   state_e      : controller states (S_LOAD codebook load, S_RUN streaming,
//                  S_FLUSH draining the end of a frame)
//   len_width()  : width of a code-length field able to hold 0..max_len
//   cnt_width()  : width of an output bit count able to hold 0..out_w
//   acc_width()  : packer accumulator width (one word plus one longest code)
package huffman_stream_encoder_pkg;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int cnt_width(input int out_w);
    return $clog2(out_w + 1);
  endfunction

  function automatic int acc_width(input int out_w, input int max_len);
    return out_w + max_len;
  endfunction

endpackage

// File: rtl/huffman_stream_encoder_if.sv
// Bus bundle for huffman_stream_encoder: codebook load port, control,
// symbol stream, packed-word stream, status and a debug view of the FSM.
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; a source holds valid and its payload until that edge, and
// ready may depend combinationally on state but never on valid.
//   slave  : the encoder's view (drives sym_ready_o, out_*, status, state)
//   master : the symbol source / word sink / software view
interface huffman_stream_encoder_if
  import huffman_stream_encoder_pkg::*;
#(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 32
);
  localparam int LEN_W = len_width(MAX_LEN);
  localparam int CNT_W = cnt_width(OUT_W);

  logic               cb_we_i;
  logic [SYM_W-1:0]   cb_sym_i;
  logic [MAX_LEN-1:0] cb_code_i;
  logic [LEN_W-1:0]   cb_len_i;
  logic               start_i;
  logic               bypass_i;
  logic               sym_valid_i;
  logic               sym_ready_o;
  logic [SYM_W-1:0]   sym_i;
  logic               last_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [OUT_W-1:0]   out_word_o;
  logic [CNT_W-1:0]   out_nbits_o;
  logic               out_last_o;
  logic               err_o;
  logic               busy_o;
  logic [31:0]        bit_count_o;
  state_e             state;

  modport slave (
    input  cb_we_i, cb_sym_i, cb_code_i, cb_len_i, start_i, bypass_i,
    input  sym_valid_i, sym_i, last_i, out_ready_i,
    output sym_ready_o, out_valid_o, out_word_o, out_nbits_o, out_last_o,
    output err_o, busy_o, bit_count_o, state
  );

  modport master (
    output cb_we_i, cb_sym_i, cb_code_i, cb_len_i, start_i, bypass_i,
    output sym_valid_i, sym_i, last_i, out_ready_i,
    input  sym_ready_o, out_valid_o, out_word_o, out_nbits_o, out_last_o,
    input  err_o, busy_o, bit_count_o, state
  );

endinterface

// File: rtl/huffman_stream_encoder_bit_packer.sv
// MSB-first bit packer with a registered output word.
//   append_valid/bits/len : add len right-aligned bits below the fill pointer
//   flush                 : frame is closing; flag the final word, emit any
//                           partial remainder left-aligned and zero-padded
//   space_ok              : fill < OUT_W, room for one more code
//   emit/emit_bits        : a word was loaded this cycle and how many bits
//   frame_done            : the frame's final word handshook (or nothing left)
//   out_*                 : packed word stream towards the channel
module huffman_stream_encoder_bit_packer
  import huffman_stream_encoder_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 32,
  parameter int LEN_W   = len_width(MAX_LEN),
  parameter int CNT_W   = cnt_width(OUT_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               append_valid,
  input  logic [MAX_LEN-1:0] append_bits,
  input  logic [LEN_W-1:0]   append_len,
  input  logic               flush,
  output logic               space_ok,
  output logic               emit,
  output logic [CNT_W-1:0]   emit_bits,
  output logic               frame_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_word,
  output logic [CNT_W-1:0]   out_nbits,
  output logic               out_last
);
  localparam int ACC_W  = acc_width(OUT_W, MAX_LEN);
  localparam int FILL_W = $clog2(ACC_W + 1);

  // acc holds pending bits left-aligned: bit ACC_W-1 is the next bit out.
  // Everything below the fill pointer is kept zero, so the top word is
  // already zero-padded when a partial word is emitted.
  logic [ACC_W-1:0]  acc, acc_base, acc_next, app_vec, app_mask;
  logic [FILL_W-1:0] fill, fill_base, fill_next, app_shift;
  logic              can_load, full_emit, part_emit;

  assign can_load  = !out_valid || out_ready;
  assign full_emit = (fill >= FILL_W'(OUT_W)) && can_load;
  assign part_emit = flush && (fill != '0) && (fill < FILL_W'(OUT_W)) && can_load;
  assign emit      = full_emit || part_emit;
  assign emit_bits = full_emit ? CNT_W'(OUT_W) : CNT_W'(fill);
  assign space_ok  = fill < FILL_W'(OUT_W);

  // A frame with no bits left and no final word outstanding (e.g. its last
  // symbol was unloaded) completes without emitting anything.
  assign frame_done = (out_valid && out_ready && out_last) ||
                      (flush && (fill == '0) && !(out_valid && out_last));

  always_comb begin
    acc_base  = acc;
    fill_base = fill;
    if (full_emit) begin
      acc_base  = acc << OUT_W;
      fill_base = fill - FILL_W'(OUT_W);
    end else if (part_emit) begin
      acc_base  = '0;
      fill_base = '0;
    end
    app_mask  = (ACC_W'(1) << append_len) - ACC_W'(1);
    app_shift = FILL_W'(ACC_W) - fill_base - FILL_W'(append_len);
    app_vec   = '0;
    fill_next = fill_base;
    if (append_valid) begin
      app_vec   = (ACC_W'(append_bits) & app_mask) << app_shift;
      fill_next = fill_base + FILL_W'(append_len);
    end
    acc_next = acc_base | app_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_nbits <= '0;
      out_last  <= 1'b0;
    end else begin
      acc  <= acc_next;
      fill <= fill_next;
      if (emit) begin
        out_valid <= 1'b1;
        out_word  <= acc[ACC_W-1 -: OUT_W];
        out_nbits <= emit_bits;
        // A full word that empties the accumulator during flush ends the frame.
        out_last  <= part_emit || (flush && (fill == FILL_W'(OUT_W)));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/huffman_stream_encoder.sv
// Streaming table-driven Huffman encoder.
//   clk_i, rst_i : clock and synchronous active-high reset
//   bus (slave)  : codebook write port, start_i, bypass_i, symbol stream
//                  (sym_valid_i/sym_ready_o/sym_i/last_i), packed word stream
//                  (out_valid_o/out_ready_i/out_word_o/out_nbits_o/out_last_o),
//                  err_o, busy_o, bit_count_o and the FSM state for debug.
// Codebook entries are written in S_LOAD; start_i enters S_RUN, an accepted
// last_i enters S_FLUSH, and the final word's handshake returns to S_RUN.
module huffman_stream_encoder
  import huffman_stream_encoder_pkg::*;
#(
  parameter int SYM_W   = 8,
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  huffman_stream_encoder_if.slave bus
);
  localparam int LEN_W = len_width(MAX_LEN);
  localparam int CNT_W = cnt_width(OUT_W);
  localparam int DEPTH = 1 << SYM_W;

  typedef struct packed {
    logic               valid;
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0]   len;
  } cb_entry_t;

  cb_entry_t          cb [DEPTH];
  cb_entry_t          entry;
  state_e             state, state_next;
  logic               load_we, len_ok, accept, do_start;
  logic               append_valid, space_ok, emit, frame_done;
  logic [MAX_LEN-1:0] append_bits;
  logic [LEN_W-1:0]   append_len;
  logic [CNT_W-1:0]   emit_bits;

  assign len_ok   = (bus.cb_len_i != '0) && (bus.cb_len_i <= LEN_W'(MAX_LEN));
  assign load_we  = (state == S_LOAD) && bus.cb_we_i;
  assign do_start = (state == S_LOAD) && bus.start_i;
  assign accept   = bus.sym_valid_i && bus.sym_ready_o;
  assign entry    = cb[bus.sym_i];

  // Bypass sends the raw symbol; otherwise an unloaded entry adds no bits.
  assign append_bits  = bus.bypass_i ? MAX_LEN'(bus.sym_i) : entry.code;
  assign append_len   = bus.bypass_i ? LEN_W'(SYM_W) : entry.len;
  assign append_valid = accept && (bus.bypass_i || entry.valid);

  assign bus.sym_ready_o = (state == S_RUN) && space_ok;
  assign bus.busy_o      = state != S_LOAD;
  assign bus.state       = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:  if (bus.start_i) state_next = S_RUN;
      S_RUN:   if (accept && bus.last_i) state_next = S_FLUSH;
      S_FLUSH: if (frame_done) state_next = S_RUN;
      default: state_next = S_LOAD;
    endcase
  end

  // Only the valid bits need reset; code/len are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) cb[i].valid <= 1'b0;
    end else if (load_we && len_ok) begin
      cb[bus.cb_sym_i] <= '{valid: 1'b1, code: bus.cb_code_i, len: bus.cb_len_i};
    end
  end

  // A bad write in the same cycle as start_i still leaves err_o set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.err_o <= 1'b0;
    end else begin
      if (do_start) bus.err_o <= 1'b0;
      if (load_we && !len_ok) bus.err_o <= 1'b1;
      if (accept && !bus.bypass_i && !entry.valid) bus.err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || do_start) bus.bit_count_o <= '0;
    else if (emit)         bus.bit_count_o <= bus.bit_count_o + 32'(emit_bits);
  end

  huffman_stream_encoder_bit_packer #(
    .MAX_LEN(MAX_LEN),
    .OUT_W  (OUT_W),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) u_packer (
    .clk         (clk_i),
    .rst         (rst_i),
    .append_valid(append_valid),
    .append_bits (append_bits),
    .append_len  (append_len),
    .flush       (state == S_FLUSH),
    .space_ok    (space_ok),
    .emit        (emit),
    .emit_bits   (emit_bits),
    .frame_done  (frame_done),
    .out_valid   (bus.out_valid_o),
    .out_ready   (bus.out_ready_i),
    .out_word    (bus.out_word_o),
    .out_nbits   (bus.out_nbits_o),
    .out_last    (bus.out_last_o)
  );

endmodule

// File: tb/tb_huffman_stream_encoder.sv
// Bench for huffman_stream_encoder with OUT_W=8 and the codebook
// A=0/1, B=10/2, C=11/2. Expected words are queued by the stimulus and
// popped by a monitor on every output handshake.
module tb_huffman_stream_encoder;
  import huffman_stream_encoder_pkg::*;

  localparam int SYM_W   = 8;
  localparam int MAX_LEN = 16;
  localparam int OUT_W   = 8;
  localparam int EXP_W   = OUT_W + 4 + 1;
  localparam int TIMEOUT = 200;

  localparam logic [7:0] SYM_A = 8'h41;
  localparam logic [7:0] SYM_B = 8'h42;
  localparam logic [7:0] SYM_C = 8'h43;
  localparam logic [7:0] SYM_Z = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_act, mon_exp;

  huffman_stream_encoder_if #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .OUT_W(OUT_W)) bus ();

  huffman_stream_encoder #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .OUT_W(OUT_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.out_valid_o && bus.out_ready_i) begin
      mon_act = {bus.out_word_o, bus.out_nbits_o, bus.out_last_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got word=%h nbits=%0d last=%0d, required no word",
                 bus.out_word_o, bus.out_nbits_o, bus.out_last_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL out_word: got word=%h nbits=%0d last=%0d, required word=%h nbits=%0d last=%0d",
                   mon_act[EXP_W-1 -: OUT_W], mon_act[4:1], mon_act[0],
                   mon_exp[EXP_W-1 -: OUT_W], mon_exp[4:1], mon_exp[0]);
        end
      end
    end
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [7:0] w, input int n, input logic l);
    exp_q.push_back({w, 4'(n), l});
  endtask

  task automatic cb_write(input logic [7:0] s, input logic [15:0] code, input logic [4:0] len);
    bus.cb_we_i   = 1'b1;
    bus.cb_sym_i  = s;
    bus.cb_code_i = code;
    bus.cb_len_i  = len;
    @(posedge clk); #1;
    bus.cb_we_i   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic send_sym(input logic [7:0] s, input logic l, input logic bp);
    int n = 0;
    bus.sym_valid_i = 1'b1;
    bus.sym_i       = s;
    bus.last_i      = l;
    bus.bypass_i    = bp;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.sym_ready_o && n < TIMEOUT);
    if (!bus.sym_ready_o) begin
      checks++;
      errors++;
      $display("FAIL sym_accept_timeout: got ready=0 for %0d cycles, required ready=1", n);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    bus.sym_valid_i = 1'b0;
    bus.last_i      = 1'b0;
    bus.bypass_i    = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.state == S_RUN && !bus.out_valid_o && exp_q.size() == 0) && n < TIMEOUT);
    if (n >= TIMEOUT) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got state=%0d pending=%0d, required S_RUN and 0 pending",
               name, bus.state, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.cb_we_i     = 1'b0;
    bus.cb_sym_i    = '0;
    bus.cb_code_i   = '0;
    bus.cb_len_i    = '0;
    bus.start_i     = 1'b0;
    bus.bypass_i    = 1'b0;
    bus.sym_valid_i = 1'b0;
    bus.sym_i       = '0;
    bus.last_i      = 1'b0;
    bus.out_ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_out_valid", 32'(bus.out_valid_o), 0);
    check("rst_err", 32'(bus.err_o), 0);
    check("rst_bit_count", bus.bit_count_o, 0);
    check("rst_sym_ready", 32'(bus.sym_ready_o), 0);
    @(posedge clk); #1;

    cb_write(SYM_A, 16'h0000, 5'd1);
    cb_write(SYM_B, 16'h0002, 5'd2);
    cb_write(SYM_C, 16'h0003, 5'd2);
    pulse_start();
    @(negedge clk);
    check("start_busy", 32'(bus.busy_o), 1);
    check("start_err", 32'(bus.err_o), 0);
    @(posedge clk); #1;

    // 1: A B C A B(last) = 0 10 11 0 10 -> 0x5A, exactly one word
    expect_word(8'h5A, 8, 1'b1);
    send_sym(SYM_A, 1'b0, 1'b0);
    send_sym(SYM_B, 1'b0, 1'b0);
    send_sym(SYM_C, 1'b0, 1'b0);
    send_sym(SYM_A, 1'b0, 1'b0);
    send_sym(SYM_B, 1'b1, 1'b0);
    wait_frame("t1");
    check("t1_bit_count", bus.bit_count_o, 8);

    // 2: A B(last) = 010 -> partial word 0x40, 3 bits
    expect_word(8'h40, 3, 1'b1);
    send_sym(SYM_A, 1'b0, 1'b0);
    send_sym(SYM_B, 1'b1, 1'b0);
    wait_frame("t2");
    check("t2_busy", 32'(bus.busy_o), 1);
    check("t2_state_run", 32'(bus.state), 32'(S_RUN));

    // 3: back-pressure; C x8 fills two words, second one stalls the input
    bus.out_ready_i = 1'b0;
    expect_word(8'hFF, 8, 1'b0);
    expect_word(8'hFF, 8, 1'b0);
    expect_word(8'h80, 2, 1'b1);
    for (int i = 0; i < 8; i++) send_sym(SYM_C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(bus.out_valid_o), 1);
      check("t3_hold_word", 32'(bus.out_word_o), 32'h0000_00FF);
      check("t3_hold_nbits", 32'(bus.out_nbits_o), 8);
      check("t3_sym_ready", 32'(bus.sym_ready_o), 0);
    end
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    send_sym(SYM_B, 1'b1, 1'b0);
    wait_frame("t3");

    // 4: raw bypass symbol
    expect_word(8'hA5, 8, 1'b1);
    send_sym(8'hA5, 1'b1, 1'b1);
    wait_frame("t4");

    // 5: codebook write in S_RUN is ignored, so Z stays unloaded
    cb_write(SYM_Z, 16'h0001, 5'd1);
    send_sym(SYM_Z, 1'b1, 1'b0);
    wait_frame("t5");
    check("t5_err_unloaded", 32'(bus.err_o), 1);
    pulse_start();
    @(negedge clk);
    check("t5_start_ignored_err", 32'(bus.err_o), 1);
    check("t5_start_ignored_state", 32'(bus.state), 32'(S_RUN));
    @(posedge clk); #1;

    // 6: reset during S_FLUSH discards the pending partial word
    bus.out_ready_i = 1'b0;
    send_sym(SYM_A, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("t6_in_flush", 32'(bus.state), 32'(S_FLUSH));
    check("t6_word_pending", 32'(bus.out_valid_o), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_out_valid", 32'(bus.out_valid_o), 0);
    check("t6_rst_busy", 32'(bus.busy_o), 0);
    check("t6_rst_err", 32'(bus.err_o), 0);
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;

    cb_write(SYM_A, 16'h0000, 5'd17);
    @(negedge clk);
    check("t6_len17_err", 32'(bus.err_o), 1);
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    check("t6_start_clears_err", 32'(bus.err_o), 0);
    @(posedge clk); #1;
    send_sym(SYM_A, 1'b1, 1'b0);
    wait_frame("t6");
    check("t6_a_cleared_err", 32'(bus.err_o), 1);

    repeat (4) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
